// File: rtl/booth_divide_fsmd.sv
// ---------------------------------------------------------------------------
// booth_divide_fsmd
//   Sequential signed integer divider (restoring algorithm on magnitudes).
//   One quotient bit is resolved per clock in CALC, then FIX applies the
//   signs. The quotient truncates toward zero and the remainder takes the
//   sign of the dividend. The start/finish handshake matches the Booth
//   multiplier, so one sequencer can drive both blocks.
//
// Ports:
//   clk_i          rising-edge clock
//   reset_ni       asynchronous active-low reset
//   enable_i       start in IDLE, acknowledge/release in DONE
//   dividend_i     signed dividend, sampled on the start edge only
//   divisor_i      signed divisor, sampled on the start edge only
//   data_valid_o   result valid (high only in DONE)
//   quotient_o     signed quotient (registered)
//   remainder_o    signed remainder (registered)
//   div_by_zero_o  last operation had a zero divisor
// ---------------------------------------------------------------------------
module booth_divide_fsmd #(
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 enable_i,
  input  logic [DATA_SIZE-1:0] dividend_i,
  input  logic [DATA_SIZE-1:0] divisor_i,
  output logic                 data_valid_o,
  output logic [DATA_SIZE-1:0] quotient_o,
  output logic [DATA_SIZE-1:0] remainder_o,
  output logic                 div_by_zero_o
);

  localparam int CW = $clog2(DATA_SIZE + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Datapath registers
  logic                 neg_quo_q, neg_quo_d;     // quotient sign
  logic                 neg_rem_q, neg_rem_d;     // remainder sign
  logic [DATA_SIZE-1:0] quo_q, quo_d;             // Q: |dividend| shifting into quotient
  logic [DATA_SIZE-1:0] mag_q, mag_d;             // M: |divisor|
  logic [DATA_SIZE:0]   acc_q, acc_d;             // A: partial remainder
  logic [CW-1:0]        count_q, count_d;

  // Output registers
  logic [DATA_SIZE-1:0] quotient_q, quotient_d;
  logic [DATA_SIZE-1:0] remainder_q, remainder_d;
  logic                 dbz_q, dbz_d;
  logic                 valid_q, valid_d;

  // Magnitudes; the most negative value maps to 2^(DATA_SIZE-1), which
  // still fits in the unsigned DATA_SIZE-bit register.
  logic [DATA_SIZE-1:0] dividend_abs;
  logic [DATA_SIZE-1:0] divisor_abs;

  // {A,Q} << 1 seen from A's side, kept one bit wider than A so the trial
  // subtraction borrow lands in the MSB.
  logic [DATA_SIZE+1:0] acc_shift;
  logic [DATA_SIZE+1:0] trial;

  assign dividend_abs = dividend_i[DATA_SIZE-1] ? -dividend_i : dividend_i;
  assign divisor_abs  = divisor_i[DATA_SIZE-1]  ? -divisor_i  : divisor_i;

  assign acc_shift = {acc_q, quo_q[DATA_SIZE-1]};
  assign trial     = acc_shift - {2'b00, mag_q};

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = (divisor_i == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (count_q == CW'(1)) begin
          state_d = FIX;
        end
      end
      FIX:  state_d = DONE;
      DONE: begin
        if (enable_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output / datapath logic
  // ---------------------------------------------------------------------
  always_comb begin
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quo_d       = quo_q;
    mag_d       = mag_q;
    acc_d       = acc_q;
    count_d     = count_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    // Valid tracks the registered state, so it is high exactly in DONE.
    valid_d     = (state_d == DONE);

    case (state_q)
      IDLE: begin
        if (enable_i) begin
          neg_quo_d   = dividend_i[DATA_SIZE-1] ^ divisor_i[DATA_SIZE-1];
          neg_rem_d   = dividend_i[DATA_SIZE-1];
          quo_d       = dividend_abs;
          mag_d       = divisor_abs;
          acc_d       = '0;
          count_d     = CW'(DATA_SIZE);
          quotient_d  = '0;
          remainder_d = '0;
          dbz_d       = 1'b0;
          if (divisor_i == '0) begin
            quotient_d  = '1;
            remainder_d = dividend_i;
            dbz_d       = 1'b1;
          end
        end
      end
      CALC: begin
        // Restore on borrow: keep the shifted A and shift in a 0.
        if (!trial[DATA_SIZE+1]) begin
          acc_d = trial[DATA_SIZE:0];
        end else begin
          acc_d = acc_shift[DATA_SIZE:0];
        end
        quo_d   = {quo_q[DATA_SIZE-2:0], ~trial[DATA_SIZE+1]};
        count_d = count_q - 1'b1;
      end
      FIX: begin
        quotient_d  = neg_quo_q ? -quo_q : quo_q;
        remainder_d = neg_rem_q ? -acc_q[DATA_SIZE-1:0] : acc_q[DATA_SIZE-1:0];
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quo_q       <= '0;
      mag_q       <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quo_q       <= quo_d;
      mag_q       <= mag_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      valid_q     <= valid_d;
    end
  end

  assign data_valid_o  = valid_q;
  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_booth_divide_fsmd.sv
// ---------------------------------------------------------------------------
// tb_booth_divide_fsmd
//   Self-checking bench for booth_divide_fsmd (DATA_SIZE = 8). Expected
//   results come from integer division in the bench and are queued when an
//   operation is launched, then popped when data_valid_o rises.
// ---------------------------------------------------------------------------
module tb_booth_divide_fsmd;

  localparam int W = 8;

  logic         clk;
  logic         reset_n;
  logic         enable;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         data_valid;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dbz;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
    int           a;
    int           b;
  } exp_t;

  exp_t sb[$];

  booth_divide_fsmd #(.DATA_SIZE(W)) dut (
    .clk_i         (clk),
    .reset_ni      (reset_n),
    .enable_i      (enable),
    .dividend_i    (dividend),
    .divisor_i     (divisor),
    .data_valid_o  (data_valid),
    .quotient_o    (quotient),
    .remainder_o   (remainder),
    .div_by_zero_o (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: truncating signed division, remainder follows the dividend.
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 0) begin
      e.q   = '1;
      e.r   = W'(a);
      e.dbz = 1'b1;
      e.lat = 1;
    end else begin
      e.q   = W'(a / b);
      e.r   = W'(a % b);
      e.dbz = 1'b0;
      e.lat = W + 2;
    end
    return e;
  endfunction

  task automatic compare_result(input int edges);
    exp_t e;
    if (sb.size() == 0) begin
      check_eq("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check_eq("latency", edges, e.lat);
    check_eq("quotient", quotient, e.q);
    check_eq("remainder", remainder, e.r);
    check_eq("div_by_zero", dbz, e.dbz);
    $display("op %0d / %0d -> q=0x%02h r=0x%02h dbz=%0b latency=%0d",
             e.a, e.b, quotient, remainder, dbz, edges);
  endtask

  // Leave DONE so the next enable pulse is seen as a start.
  task automatic release_done();
    if (data_valid) begin
      @(negedge clk);
      enable = 1'b1;
      @(posedge clk);
      #1;
      enable = 1'b0;
    end
  endtask

  task automatic run_op(input int a, input int b, input bit scramble);
    int edges;
    release_done();
    @(negedge clk);
    dividend = W'(a);
    divisor  = W'(b);
    enable   = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    enable = 1'b0;
    edges  = 1;
    while (!data_valid && edges < 40) begin
      @(negedge clk);
      if (scramble) begin
        dividend = W'($urandom);
        divisor  = W'($urandom);
      end
      @(posedge clk);
      #1;
      edges++;
    end
    check_eq("valid_seen", data_valid, 1'b1);
    compare_result(edges);
  endtask

  initial begin
    int low_cycles;
    int edges;

    reset_n  = 1'b0;
    enable   = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", data_valid, 1'b0);
    check_eq("rst_quotient", quotient, 8'h00);
    check_eq("rst_remainder", remainder, 8'h00);
    check_eq("rst_dbz", dbz, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic divide and result hold.
    run_op(100, 7, 1'b0);
    repeat (20) begin
      @(posedge clk);
      #1;
      check_eq("hold_valid", data_valid, 1'b1);
      check_eq("hold_quotient", quotient, 8'h0E);
      check_eq("hold_remainder", remainder, 8'h02);
    end

    // Sign combinations and edge operands.
    run_op(-100, 7, 1'b0);
    run_op(100, -7, 1'b0);
    run_op(-100, -7, 1'b0);
    run_op(-128, -1, 1'b0);
    run_op(-128, 1, 1'b0);
    run_op(3, 5, 1'b0);
    run_op(127, 127, 1'b0);

    // Divide by zero, then a normal operation clears the flag.
    run_op(5, 0, 1'b0);
    run_op(9, 3, 1'b0);

    // Operands toggling during CALC must not disturb the result.
    run_op(-77, 9, 1'b1);
    run_op(123, -11, 1'b1);

    // Asynchronous reset in the middle of CALC.
    release_done();
    @(negedge clk);
    dividend = 8'd77;
    divisor  = 8'd5;
    enable   = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("midrst_valid", data_valid, 1'b0);
    check_eq("midrst_quotient", quotient, 8'h00);
    check_eq("midrst_remainder", remainder, 8'h00);
    check_eq("midrst_dbz", dbz, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    low_cycles = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (!data_valid) low_cycles++;
    end
    check_eq("midrst_idle_cycles", low_cycles, 12);
    run_op(50, 6, 1'b0);

    // enable held high across two operations.
    release_done();
    @(negedge clk);
    dividend = 8'd20;
    divisor  = 8'd3;
    enable   = 1'b1;
    sb.push_back(model(20, 3));
    @(posedge clk);
    #1;
    edges = 1;
    while (!data_valid && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check_eq("hs1_valid_seen", data_valid, 1'b1);
    compare_result(edges);
    dividend = W'(-20);
    divisor  = 8'd3;
    sb.push_back(model(-20, 3));
    low_cycles = 0;
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (!data_valid) low_cycles++;
    end while (!data_valid && edges < 40);
    enable = 1'b0;
    check_eq("hs_gap_cycles", low_cycles, W + 2);
    check_eq("hs2_valid_seen", data_valid, 1'b1);
    compare_result(W + 2);

    // A few random operations through the model.
    for (int i = 0; i < 8; i++) begin
      int a;
      int b;
      a = $signed(W'($urandom));
      b = $signed(W'($urandom));
      run_op(a, b, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
